// File: rtl/axi4lite_master_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite master bridge.
package axi4lite_master_bridge_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned STRB_W  = 4;
   localparam int unsigned PROT_W  = 3;
   localparam int unsigned RESP_W  = 2;
   localparam int unsigned STATE_W = 3;

   localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
   localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
   localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

   localparam logic [STATE_W-1:0] ST_IDLE_ENC    = 3'd0;
   localparam logic [STATE_W-1:0] ST_WR_ENC      = 3'd1;
   localparam logic [STATE_W-1:0] ST_WR_RESP_ENC = 3'd2;
   localparam logic [STATE_W-1:0] ST_RD_ADDR_ENC = 3'd3;
   localparam logic [STATE_W-1:0] ST_RD_DATA_ENC = 3'd4;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = ST_IDLE_ENC,
      ST_WR      = ST_WR_ENC,
      ST_WR_RESP = ST_WR_RESP_ENC,
      ST_RD_ADDR = ST_RD_ADDR_ENC,
      ST_RD_DATA = ST_RD_DATA_ENC
   } state_e;

   // Write payload latched at request acceptance.
   typedef struct packed {
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } wr_payload_t;

   // SLVERR and DECERR both report as a host-visible error.
   function automatic logic resp_is_err(input logic [RESP_W-1:0] resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage

// File: rtl/axi4lite_master_bridge_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4lite_master_bridge_if
   import axi4lite_master_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
);

   logic                awvalid;
   logic                awready;
   logic [ADDR_W-1:0]   awaddr;
   logic [PROT_W-1:0]   awprot;
   logic                wvalid;
   logic                wready;
   logic [DATA_W-1:0]   wdata;
   logic [STRB_W-1:0]   wstrb;
   logic                bvalid;
   logic                bready;
   logic [RESP_W-1:0]   bresp;
   logic                arvalid;
   logic                arready;
   logic [ADDR_W-1:0]   araddr;
   logic [PROT_W-1:0]   arprot;
   logic                rvalid;
   logic                rready;
   logic [DATA_W-1:0]   rdata;
   logic [RESP_W-1:0]   rresp;

   modport master (
      output awvalid, awaddr, awprot,
      input  awready,
      output wvalid, wdata, wstrb,
      input  wready,
      input  bvalid, bresp,
      output bready,
      output arvalid, araddr, arprot,
      input  arready,
      input  rvalid, rdata, rresp,
      output rready
   );

   modport slave (
      input  awvalid, awaddr, awprot,
      output awready,
      input  wvalid, wdata, wstrb,
      output wready,
      output bvalid, bresp,
      input  bready,
      input  arvalid, araddr, arprot,
      output arready,
      output rvalid, rdata, rresp,
      input  rready
   );

endinterface

// File: rtl/axi4lite_master_bridge_timer.sv
// Transaction watchdog counter; only built when AXI4LITE_MST_TIMEOUT_EN is defined.
// expire_o is high while the count sits at TIMEOUT_CYCLES-1.
`ifdef AXI4LITE_MST_TIMEOUT_EN
module axi4lite_mst_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic aclk,
   input  logic areset_n,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expire_q, expire_d;

   // Clear on load, count while enabled; expiry is precomputed from the next count.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      expire_d = (cnt_d == CNT_W'(TIMEOUT_CYCLES - 1));
   end

   // Counter and expiry registers.
   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         cnt_q    <= '0;
         expire_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         expire_q <= expire_d;
      end
   end

   assign expire_o = expire_q;

endmodule
`endif

// File: rtl/axi4lite_master_bridge.sv
// Host request/response port to single-outstanding AXI4-Lite master.
// Optional watchdog abort enabled by defining AXI4LITE_MST_TIMEOUT_EN.
module axi4lite_master_bridge
   import axi4lite_master_bridge_pkg::*;
#(
   parameter int unsigned       ADDR_W         = 32,
   parameter logic [PROT_W-1:0] PROT           = 3'b000,
   parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
   input  logic                 aclk,
   input  logic                 areset_n,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [ADDR_W-1:0]    req_addr_i,
   input  logic [DATA_W-1:0]    req_wdata_i,
   input  logic [STRB_W-1:0]    req_wstrb_i,
   output logic                 rsp_valid_o,
   output logic [DATA_W-1:0]    rsp_rdata_o,
   output logic                 rsp_err_o,
   output logic                 rsp_timeout_o,
   axi4lite_master_bridge_if.master m_axi
);

   state_e            state_q, state_d;
   logic              req_ready_q, req_ready_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              bready_q, bready_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   wr_payload_t       wpay_q, wpay_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;

   logic              accept_c;
   logic              complete_c;
   logic              expire_c;

   assign accept_c   = req_valid_i && req_ready_q;
   assign complete_c = ((state_q == ST_WR_RESP) && m_axi.bvalid) ||
                       ((state_q == ST_RD_DATA) && m_axi.rvalid);

`ifdef AXI4LITE_MST_TIMEOUT_EN
   logic timer_load_c;
   logic timer_en_c;

   assign timer_load_c = (state_q == ST_IDLE) && accept_c;
   assign timer_en_c   = (state_q != ST_IDLE);

   axi4lite_mst_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .aclk     (aclk),
      .areset_n (areset_n),
      .load_i   (timer_load_c),
      .en_i     (timer_en_c),
      .expire_o (expire_c)
   );
`else
   logic unused_timeout_cfg;

   assign expire_c           = 1'b0;
   assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

   // Next-state and registered-output logic; watchdog abort overrides at the end.
   always_comb begin
      state_d       = state_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      arvalid_d     = arvalid_q;
      rready_d      = rready_q;
      addr_d        = addr_q;
      wpay_d        = wpay_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;

      case (state_q)
         ST_IDLE: begin
            bready_d = 1'b0;
            rready_d = 1'b0;
            if (accept_c) begin
               addr_d       = req_addr_i;
               wpay_d.wdata = req_wdata_i;
               wpay_d.wstrb = req_wstrb_i;
               if (req_we_i) begin
                  state_d   = ST_WR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = ST_RD_ADDR;
                  arvalid_d = 1'b1;
               end
            end
         end
         ST_WR: begin
            awvalid_d = awvalid_q && !m_axi.awready;
            wvalid_d  = wvalid_q && !m_axi.wready;
            if (!awvalid_d && !wvalid_d) begin
               state_d  = ST_WR_RESP;
               bready_d = 1'b1;
            end
         end
         ST_WR_RESP: begin
            if (m_axi.bvalid) begin
               state_d       = ST_IDLE;
               bready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = resp_is_err(m_axi.bresp);
               rsp_timeout_d = 1'b0;
            end
         end
         ST_RD_ADDR: begin
            if (m_axi.arready) begin
               state_d   = ST_RD_DATA;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         ST_RD_DATA: begin
            if (m_axi.rvalid) begin
               state_d       = ST_IDLE;
               rready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = m_axi.rdata;
               rsp_err_d     = resp_is_err(m_axi.rresp);
               rsp_timeout_d = 1'b0;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
         end
      endcase

      // Watchdog expiry without a completing B/R handshake abandons the transaction.
      if (expire_c && (state_q != ST_IDLE) && !complete_c) begin
         state_d       = ST_IDLE;
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         bready_d      = 1'b0;
         arvalid_d     = 1'b0;
         rready_d      = 1'b0;
         rsp_valid_d   = 1'b1;
         rsp_rdata_d   = '0;
         rsp_err_d     = 1'b1;
         rsp_timeout_d = 1'b1;
      end

      req_ready_d = (state_d == ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         state_q       <= ST_IDLE;
         req_ready_q   <= 1'b1;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         addr_q        <= '0;
         wpay_q        <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_ready_q   <= req_ready_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         addr_q        <= addr_d;
         wpay_q        <= wpay_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign req_ready_o   = req_ready_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rsp_rdata_q;
   assign rsp_err_o     = rsp_err_q;
   assign rsp_timeout_o = rsp_timeout_q;

   assign m_axi.awvalid = awvalid_q;
   assign m_axi.awaddr  = addr_q;
   assign m_axi.awprot  = PROT;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.wdata   = wpay_q.wdata;
   assign m_axi.wstrb   = wpay_q.wstrb;
   assign m_axi.bready  = bready_q;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.araddr  = addr_q;
   assign m_axi.arprot  = PROT;
   assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// Scoreboard bench for axi4lite_master_bridge against a two-register AXI4-Lite slave model.
// Watchdog scenario runs only when AXI4LITE_MST_TIMEOUT_EN is defined.
module tb_axi4lite_master_bridge;

   localparam int unsigned ADDR_W = 32;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        to;
      logic        chk_rd;
   } exp_t;

   logic              aclk        = 1'b0;
   logic              areset_n    = 1'b0;
   logic              req_valid_i = 1'b0;
   logic              req_ready_o;
   logic              req_we_i    = 1'b0;
   logic [ADDR_W-1:0] req_addr_i  = '0;
   logic [31:0]       req_wdata_i = '0;
   logic [3:0]        req_wstrb_i = '0;
   logic              rsp_valid_o;
   logic [31:0]       rsp_rdata_o;
   logic              rsp_err_o;
   logic              rsp_timeout_o;

   axi4lite_master_bridge_if #(.ADDR_W(ADDR_W)) axi ();

   axi4lite_master_bridge #(
      .ADDR_W         (ADDR_W),
      .PROT           (3'b000),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .aclk          (aclk),
      .areset_n      (areset_n),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_we_i      (req_we_i),
      .req_addr_i    (req_addr_i),
      .req_wdata_i   (req_wdata_i),
      .req_wstrb_i   (req_wstrb_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_rdata_o   (rsp_rdata_o),
      .rsp_err_o     (rsp_err_o),
      .rsp_timeout_o (rsp_timeout_o),
      .m_axi         (axi)
   );

   always #5 aclk = ~aclk;

   int   nchecks = 0;
   int   nerrors = 0;
   exp_t exp_q[$];
   int   rsp_cnt = 0;
   int   last_rsp_cyc = 0;
   int   acc_cyc = 0;
   int   cyc = 0;

   // Slave model state and knobs
   logic [31:0] areg = '0;
   logic [31:0] breg = '0;
   bit          aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
   logic [31:0] aw_addr_s = '0, w_data_s = '0, r_data_s = '0;
   logic [3:0]  w_strb_s = '0;
   int          aw_wait = 0;
   int          aw_delay = 0;
   bit          never_b = 0, r_hold = 0, slv_flush = 0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   int          aw_hi_cnt = 0, w_hi_cnt = 0, b_hs_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   // Slave: sample handshakes at the active edge
   initial forever begin
      @(posedge aclk);
      cyc++;
      if (!areset_n || slv_flush) begin
         aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; aw_wait = 0;
      end else begin
         if (axi.awvalid) aw_hi_cnt++;
         if (axi.wvalid)  w_hi_cnt++;
         if (axi.bvalid && axi.bready) begin
            b_pend = 0;
            b_hs_cnt++;
         end
         if (axi.awvalid && axi.awready) begin
            aw_got = 1; aw_addr_s = axi.awaddr; aw_wait = 0;
            check("awprot", 32'(axi.awprot), 32'h0);
         end else if (axi.awvalid) begin
            aw_wait++;
         end
         if (axi.wvalid && axi.wready) begin
            w_got = 1; w_data_s = axi.wdata; w_strb_s = axi.wstrb;
         end
         if (aw_got && w_got && !b_pend) begin
            if (aw_addr_s == 32'h4) breg = merge(breg, w_data_s, w_strb_s);
            else                    areg = merge(areg, w_data_s, w_strb_s);
            b_pend = 1; aw_got = 0; w_got = 0;
         end
         if (axi.rvalid && axi.rready) r_pend = 0;
         if (axi.arvalid && axi.arready) begin
            r_pend = 1;
            r_data_s = (axi.araddr == 32'h4) ? breg : areg;
            check("arprot", 32'(axi.arprot), 32'h0);
         end
      end
   end

   // Slave: drive responses away from the active edge
   initial forever begin
      @(negedge aclk);
      axi.awready = axi.awvalid && !aw_got && (aw_wait >= aw_delay);
      axi.wready  = axi.wvalid && !w_got;
      axi.bvalid  = b_pend && !never_b;
      axi.bresp   = bresp_cfg;
      axi.arready = axi.arvalid && !r_pend;
      axi.rvalid  = r_pend && !r_hold;
      axi.rdata   = r_pend ? r_data_s : 32'h0;
      axi.rresp   = rresp_cfg;
   end

   // Monitor: pop and compare on every completion pulse
   initial forever begin
      exp_t e;
      @(negedge aclk);
      if (rsp_valid_o === 1'b1) begin
         rsp_cnt++;
         last_rsp_cyc = cyc;
         if (exp_q.size() == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
         end else begin
            e = exp_q.pop_front();
            check("rsp_err", 32'(rsp_err_o), 32'(e.err));
            check("rsp_timeout", 32'(rsp_timeout_o), 32'(e.to));
            check("req_ready_at_rsp", 32'(req_ready_o), 32'h1);
            if (e.chk_rd) check("rsp_rdata", rsp_rdata_o, e.rdata);
         end
      end
   end

   // Issue one host request (called at a negedge) and wait for its response.
   task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] exp_rd,
                         input bit exp_err, input bit exp_to, input bit chk_rd);
      int   n;
      int   start;
      exp_t e;
      n = 0;
      while (req_ready_o !== 1'b1 && n < 100) begin
         @(negedge aclk);
         n++;
      end
      check("req_ready_before_req", 32'(req_ready_o), 32'h1);
      e.rdata = exp_rd; e.err = exp_err; e.to = exp_to; e.chk_rd = chk_rd;
      exp_q.push_back(e);
      start = rsp_cnt;
      req_valid_i = 1'b1;
      req_we_i    = we;
      req_addr_i  = addr;
      req_wdata_i = wdata;
      req_wstrb_i = strb;
      @(posedge aclk);
      @(negedge aclk);
      req_valid_i = 1'b0;
      acc_cyc = cyc;
      n = 0;
      while (rsp_cnt == start && n < 100) begin
         @(negedge aclk);
         n++;
      end
      if (rsp_cnt == start) begin
         nchecks++;
         nerrors++;
         $display("FAIL rsp_wait: got no rsp_valid within 100 cycles expected one");
         void'(exp_q.pop_front());
      end else begin
         @(negedge aclk);
         check("rsp_valid_single_pulse", 32'(rsp_valid_o), 32'h0);
      end
   endtask

   initial begin
      int n;
      int aw0, w0, b0, r0;
      repeat (3) @(negedge aclk);
      areset_n = 1'b1;
      @(negedge aclk);

      // Reset state
      check("rst_req_ready", 32'(req_ready_o), 32'h1);
      check("rst_awvalid", 32'(axi.awvalid), 32'h0);
      check("rst_wvalid", 32'(axi.wvalid), 32'h0);
      check("rst_arvalid", 32'(axi.arvalid), 32'h0);
      check("rst_bready", 32'(axi.bready), 32'h0);
      check("rst_rready", 32'(axi.rready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
      check("rst_rsp_err", 32'(rsp_err_o), 32'h0);
      check("rst_rsp_timeout", 32'(rsp_timeout_o), 32'h0);
      check("rst_rsp_rdata", rsp_rdata_o, 32'h0);

      // 1: full write
      do_req(1, 32'h4, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0, 0);
      check("t1_breg", breg, 32'hDEADBEEF);

      // 2: read back both registers
      do_req(0, 32'h4, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 1);
      do_req(0, 32'h0, 32'h0, 4'h0, 32'h00000000, 0, 0, 1);

      // 3: awready stalled 3 cycles, partial strobes
      aw_delay = 3;
      aw0 = aw_hi_cnt; w0 = w_hi_cnt; b0 = b_hs_cnt; r0 = rsp_cnt;
      do_req(1, 32'h0, 32'hFFFFA5A5, 4'h3, 32'h0, 0, 0, 0);
      check("t3_awvalid_cycles", 32'(aw_hi_cnt - aw0), 32'd4);
      check("t3_wvalid_cycles", 32'(w_hi_cnt - w0), 32'd1);
      check("t3_b_handshakes", 32'(b_hs_cnt - b0), 32'd1);
      check("t3_rsp_count", 32'(rsp_cnt - r0), 32'd1);
      aw_delay = 0;
      do_req(0, 32'h0, 32'h0, 4'h0, 32'h0000A5A5, 0, 0, 1);

      // 4: error responses
      bresp_cfg = 2'b10;
      do_req(1, 32'h4, 32'h11223344, 4'hF, 32'h0, 1, 0, 0);
      bresp_cfg = 2'b00;
      rresp_cfg = 2'b11;
      do_req(0, 32'h4, 32'h0, 4'h0, 32'h11223344, 1, 0, 1);
      rresp_cfg = 2'b00;

`ifdef AXI4LITE_MST_TIMEOUT_EN
      // 5: watchdog abort on a missing write response
      never_b = 1;
      do_req(1, 32'h4, 32'hCAFEF00D, 4'hF, 32'h0, 1, 1, 1);
      check("t5_timeout_latency", 32'(last_rsp_cyc - acc_cyc), 32'd16);
      never_b = 0;
      slv_flush = 1;
      @(negedge aclk);
      slv_flush = 0;
      do_req(0, 32'h0, 32'h0, 4'h0, 32'h0000A5A5, 0, 0, 1);
`endif

      // 6: reset pulse while waiting for read data
      r_hold = 1;
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_addr_i  = 32'h4;
      @(posedge aclk);
      @(negedge aclk);
      req_valid_i = 1'b0;
      n = 0;
      while (axi.rready !== 1'b1 && n < 20) begin
         @(negedge aclk);
         n++;
      end
      check("t6_reached_rd_data", 32'(axi.rready), 32'h1);
      areset_n = 1'b0;
      @(negedge aclk);
      areset_n = 1'b1;
      check("t6_arvalid", 32'(axi.arvalid), 32'h0);
      check("t6_rready", 32'(axi.rready), 32'h0);
      check("t6_req_ready", 32'(req_ready_o), 32'h1);
      check("t6_rsp_valid", 32'(rsp_valid_o), 32'h0);
      r_hold = 0;
      repeat (4) @(negedge aclk);
      check("t6_no_late_rsp", 32'(rsp_valid_o), 32'h0);
      do_req(1, 32'h0, 32'h12345678, 4'hF, 32'h0, 0, 0, 0);
      check("t6_areg", areg, 32'h12345678);
      do_req(0, 32'h0, 32'h0, 4'h0, 32'h12345678, 0, 0, 1);

      repeat (3) @(negedge aclk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish by 200000 expected earlier finish");
      $fatal(1, "global timeout");
   end

endmodule
